// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NREQ requesters,
// with a registered valid/ready result stage.

// Plain ripple-carry adder: sum = a + b + cin, carry chain bit by bit.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Carry rippled through a block-local variable so the chain stays acyclic.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module adder_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
) (
    input  logic                       Clk_i,
    input  logic                       Rst_ni,
    input  logic [NREQ-1:0]            Req_i,
    input  logic [NREQ*WIDTH-1:0]      Number1_i,
    input  logic [NREQ*WIDTH-1:0]      Number2_i,
    input  logic [NREQ-1:0]            Carry_i,
    output logic [NREQ-1:0]            Gnt_o,
    output logic                       Valid_o,
    input  logic                       Ready_i,
    output logic [WIDTH-1:0]           Result_o,
    output logic                       Carry_o,
    output logic [$clog2(NREQ)-1:0]    Id_o
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  sel;
    logic             found;
    logic             stage_free;
    logic             grant;
    logic [NREQ-1:0]  gnt_vec;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign stage_free = !Valid_o || Ready_i;

    // Priority search: first requesting index at or above ptr, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NREQ);
            if (!found && Req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // One-hot accept, suppressed under backpressure and while reset is held.
    always_comb begin
        gnt_vec = '0;
        if (Rst_ni && stage_free && found) begin
            gnt_vec[sel] = 1'b1;
        end
    end

    assign Gnt_o = gnt_vec;
    assign grant = |gnt_vec;

    // Operand mux feeding the single shared adder.
    assign op_a = Number1_i[sel*WIDTH +: WIDTH];
    assign op_b = Number2_i[sel*WIDTH +: WIDTH];
    assign op_c = Carry_i[sel];

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_c),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Output stage and round-robin pointer; grant overwrites even while popping.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            Valid_o  <= 1'b0;
            Result_o <= '0;
            Carry_o  <= 1'b0;
            Id_o     <= '0;
            ptr      <= '0;
        end else if (grant) begin
            Valid_o  <= 1'b1;
            Result_o <= add_sum;
            Carry_o  <= add_cout;
            Id_o     <= sel;
            ptr      <= (sel == ID_W'(NREQ - 1)) ? '0 : sel + 1'b1;
        end else if (Valid_o && Ready_i) begin
            Valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (WIDTH=32, NREQ=4).
module tb_adder_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] num1;
    logic [N*W-1:0] num2;
    logic [N-1:0]   cin;
    logic [N-1:0]   gnt;
    logic           valid;
    logic           ready;
    logic [W-1:0]   result;
    logic           cout;
    logic [1:0]     id;

    int tests;
    int failed;

    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    logic         c_v [N];
    logic [W:0]   exp_sum;

    adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .Clk_i     (clk),
        .Rst_ni    (rst_n),
        .Req_i     (req),
        .Number1_i (num1),
        .Number2_i (num2),
        .Carry_i   (cin),
        .Gnt_o     (gnt),
        .Valid_o   (valid),
        .Ready_i   (ready),
        .Result_o  (result),
        .Carry_o   (cout),
        .Id_o      (id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_v[k] = a;
        b_v[k] = b;
        c_v[k] = c;
        num1[k*W +: W] = a;
        num2[k*W +: W] = b;
        cin[k] = c;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [5];
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        ready  = 1'b1;
        req    = '0;
        num1   = '0;
        num2   = '0;
        cin    = '0;

        // Reset held: outputs cleared, no grant even with a request pending.
        set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req = 4'b0001;
        tick();
        tick();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry", 64'(cout), 64'd0);
        check("rst_id", 64'(id), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        #3 rst_n = 1'b1;

        // Single request: FFFFFFFF + 1 + 0 -> 0 carry 1.
        #1;
        check("single_gnt", 64'(gnt), 64'h1);
        tick();
        check("single_valid", 64'(valid), 64'd1);
        check("single_result", 64'(result), 64'h0);
        check("single_carry", 64'(cout), 64'd1);
        check("single_id", 64'(id), 64'd0);

        // Same request with carry-in: -> 1 carry 1.
        set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        #1;
        check("single_cin_gnt", 64'(gnt), 64'h1);
        tick();
        check("single_cin_result", 64'(result), 64'h1);
        check("single_cin_carry", 64'(cout), 64'd1);

        // Drop the request: result pops, registers hold.
        req = '0;
        tick();
        check("pop_valid", 64'(valid), 64'd0);
        check("pop_result_hold", 64'(result), 64'h1);

        // Re-reset so round robin starts from ptr 0.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 32'h8000_0000 + 32'(k), 32'h8000_0000 - 32'(k * 3), 1'(k));
        end
        req = 4'b1111;
        seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(4'b0001 << seq[i]));
            tick();
            exp_sum = ref_add(a_v[seq[i]], b_v[seq[i]], c_v[seq[i]]);
            check($sformatf("rr_id%0d", i), 64'(id), 64'(seq[i]));
            check($sformatf("rr_valid%0d", i), 64'(valid), 64'd1);
            check($sformatf("rr_sum%0d", i), 64'({cout, result}), 64'(exp_sum));
        end

        // Backpressure: no grant, outputs hold for 3 cycles.
        ready = 1'b0;
        exp_sum = ref_add(a_v[0], b_v[0], c_v[0]);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_gnt%0d", i), 64'(gnt), 64'd0);
            tick();
            check($sformatf("bp_valid%0d", i), 64'(valid), 64'd1);
            check($sformatf("bp_hold%0d", i), 64'({cout, result}), 64'(exp_sum));
            check($sformatf("bp_id%0d", i), 64'(id), 64'd0);
        end

        // Release: grant and pop on the same edge; ptr was 1.
        ready = 1'b1;
        #1;
        check("bp_release_gnt", 64'(gnt), 64'h2);
        tick();
        exp_sum = ref_add(a_v[1], b_v[1], c_v[1]);
        check("bp_release_valid", 64'(valid), 64'd1);
        check("bp_release_id", 64'(id), 64'd1);
        check("bp_release_sum", 64'({cout, result}), 64'(exp_sum));

        // Pointer wrap: ptr=2, grant 3 -> ptr 0; then 1010 grants 1; then 1000 grants 3.
        req = 4'b1000;
        #1;
        check("wrap_gnt3", 64'(gnt), 64'h8);
        tick();
        check("wrap_id3", 64'(id), 64'd3);
        req = 4'b1010;
        #1;
        check("wrap_gnt1", 64'(gnt), 64'h2);
        tick();
        check("wrap_id1", 64'(id), 64'd1);
        req = 4'b1000;
        #1;
        check("wrap_gnt3b", 64'(gnt), 64'h8);
        tick();
        check("wrap_id3b", 64'(id), 64'd3);

        // Mid-operation reset: Valid drops asynchronously, ptr back to 0.
        req = 4'b0110;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_gnt", 64'(gnt), 64'd0);
        #1 rst_n = 1'b1;
        #1;
        check("midrst_gnt_after", 64'(gnt), 64'h2);
        tick();
        check("midrst_id", 64'(id), 64'd1);
        check("midrst_valid_after", 64'(valid), 64'd1);

        // Arithmetic sweep, one case per requester, hand-computed sums.
        begin
            logic [W-1:0] sa [4];
            logic [W-1:0] sb [4];
            logic         sc [4];
            logic [W:0]   hand [4];
            sa = '{32'd0, 32'd1, 32'd0, 32'd1};
            sb = '{32'd1, 32'd1, 32'd0, 32'd1};
            sc = '{1'b0, 1'b0, 1'b1, 1'b1};
            hand = '{33'd1, 33'd2, 33'd1, 33'd3};
            for (int k = 0; k < 4; k++) begin
                set_op(k, sa[k], sb[k], sc[k]);
                req = 4'b0001 << k;
                #1;
                check($sformatf("arith_gnt%0d", k), 64'(gnt), 64'(4'b0001 << k));
                tick();
                check($sformatf("arith_hand%0d", k), 64'({cout, result}), 64'(hand[k]));
                check($sformatf("arith_model%0d", k), 64'({cout, result}), 64'(ref_add(sa[k], sb[k], sc[k])));
                check($sformatf("arith_id%0d", k), 64'(id), 64'(k));
            end
        end

        // Idle with ready: result pops, ptr does not move on idle.
        req = '0;
        tick();
        check("final_valid", 64'(valid), 64'd0);
        check("final_result_hold", 64'({cout, result}), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one WIDTH-bit `ripple_carry_adder` between NREQ requesters. Each requester presents two operands and a carry-in. The arbiter grants one requester per cycle and drives the shared adder with that requester's operands. It registers the sum, the carry-out and the requester index into an output stage that uses a valid/ready handshake. The block sits between several datapath clients and a single adder instance, so the adder area is paid once.

## Interface
- WIDTH, 32, operand and result width; passed to the internal `ripple_carry_adder`
- NREQ, 4, number of requesters; 2..16
- Clk_i  input  1  clock; all state updates on its rising edge
- Rst_ni  input  1  asynchronous, active-low reset
- Req_i  input  NREQ  bit k: requester k has an operation pending
- Number1_i  input  NREQ*WIDTH  operand A; slice k is [k*WIDTH +: WIDTH]
- Number2_i  input  NREQ*WIDTH  operand B; sliced the same way
- Carry_i  input  NREQ  carry-in for each requester
- Gnt_o  output  NREQ  one-hot accept; combinational
- Valid_o  output  1  output stage holds a result
- Ready_i  input  1  consumer accepts the result
- Result_o  output  WIDTH  registered sum
- Carry_o  output  1  registered carry-out
- Id_o  output  clog2(NREQ)  index of the requester that produced Result_o

## Operation
- Requester k raises Req_i[k] with stable operands and keeps them until it sees Gnt_o[k]=1 on a rising edge. That edge completes the transfer.
- A requester may drop Req_i without a grant. Its request is then simply not served.
- stage_free = !Valid_o || Ready_i.
- Grant rule:
  - If stage_free and any Req_i bit is set, Gnt_o is one-hot on the first requesting index found by searching upward from ptr, modulo NREQ.
  - Otherwise Gnt_o is 0.
- Gnt_o is 0 while Rst_ni is low.
- The selected operands are muxed into the single adder instance combinationally.
- On a granting edge:
  - Result_o and Carry_o are loaded from the adder.
  - Id_o is loaded with the granted index.
  - Valid_o is set to 1.
  - ptr is set to (granted index + 1) mod NREQ.
- On an edge with Valid_o && Ready_i and no grant, Valid_o goes to 0. Result_o, Carry_o and Id_o keep their values.
- Simultaneous pop and grant: the register is overwritten and Valid_o stays 1. This gives full throughput of one operation per cycle.
- On an edge with Valid_o && !Ready_i, all output registers hold and Gnt_o is 0. This is backpressure.
- ptr advances only on a grant, never on idle cycles.
- Arithmetic: {Carry_o, Result_o} = A + B + cin, computed mod 2^(WIDTH+1). There are no other flags.
- Output reset values:
  - Valid_o = 0, Result_o = 0, Carry_o = 0, Id_o = 0.
  - ptr = 0, so requester 0 has highest priority first.
- Reset asserted mid-operation: the pending result is discarded and Valid_o drops immediately, asynchronously. Requesters that were not granted must keep requesting.

## Timing
- Grant to Valid_o: 1 cycle. Result_o is valid on the edge after the grant edge.
- Steady throughput: 1 result per cycle while Ready_i=1.
- Gnt_o depends combinationally on Req_i, Valid_o, Ready_i and ptr. It has no combinational path from Number1_i, Number2_i or Carry_i.
- Critical path: ptr/Req_i through the priority search, then the operand mux, then the ripple carry chain, then the Result_o register.
- Fairness: a continuously requesting requester is granted within NREQ grants.

## Test plan
- Reset and single request:
  - Hold Rst_ni low: Valid_o=0, Result_o=0, Gnt_o=0.
  - Release reset, then Req_i=0001 with A=32'hFFFF_FFFF, B=1, cin=0: Gnt_o=0001, and on the next cycle Valid_o=1, Result_o=0, Carry_o=1, Id_o=0.
  - Same request with cin=1: Result_o=1, Carry_o=1.
- Round robin: Req_i=1111 held continuously with Ready_i=1. The grant sequence is 0,1,2,3,0. Each Id_o matches its grant one cycle later, and Valid_o stays high throughout.
- Backpressure:
  - Ready_i=0 with Valid_o=1: Gnt_o=0 for 3 cycles and Result_o holds its value.
  - Raise Ready_i: the grant and the pop happen on the same edge, and the new result appears with Valid_o still 1.
- Pointer wrap:
  - Grant requester 3, so ptr becomes 0.
  - Then Req_i=1010: requester 1 is granted.
  - Then with Req_i=1000: requester 3 is granted.
- Mid-operation reset:
  - Pulse Rst_ni low for 2 ns while Valid_o=1 and Req_i=0110: Valid_o drops immediately.
  - After release, the first grant goes to requester 1 because ptr is back at 0.
- Arithmetic sweep: (0,1,0)→1/0, (1,1,0)→2/0, (0,0,1)→1/0, (1,1,1)→3/0. Each case is run through a different requester, and every case is checked against a reference model of A+B+cin.
